// File: rtl/pa_soc_timer.sv
// pa_soc_timer: memory-mapped 32-bit timer peripheral with programmable
// prescaler, compare-match up-counter, periodic/one-shot mode and a level
// interrupt. Read data is combinational for the bus matrix read mux.
module pa_soc_timer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PSC_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              irq_o
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRESC  = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_CMP    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);
    localparam logic [PSC_W-1:0]  PSC_ONE = PSC_W'(1);

    // Architectural state
    logic              en;
    logic              ie;
    logic              oneshot;
    logic [PSC_W-1:0]  presc;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] cmp;
    logic              match;
    logic [PSC_W-1:0]  psc_cnt;

    // Decode and event strobes
    logic [2:0] sel;
    logic       wr_ctrl;
    logic       wr_presc;
    logic       wr_count;
    logic       wr_cmp;
    logic       wr_status;
    logic       tick;
    logic       hit;

    // Address bits outside the word-offset field are intentionally ignored
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:5], addr_i[1:0]};

    assign sel       = addr_i[4:2];
    assign wr_ctrl   = we_i && (sel == OFF_CTRL);
    assign wr_presc  = we_i && (sel == OFF_PRESC);
    assign wr_count  = we_i && (sel == OFF_COUNT);
    assign wr_cmp    = we_i && (sel == OFF_CMP);
    assign wr_status = we_i && (sel == OFF_STATUS);

    // A tick fires on the last prescaler cycle; a hit is a tick that finds COUNT at CMP
    assign tick = en && (psc_cnt == presc);
    assign hit  = tick && (count == cmp);

    // Prescaler: restarts on disable, on reconfiguration and after each tick
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc_cnt <= '0;
        end else if (!en || wr_ctrl || wr_presc || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_ONE;
        end
    end

    // Control register; a software write wins over the one-shot self-disable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
        end else if (wr_ctrl) begin
            en      <= data_i[0];
            ie      <= data_i[1];
            oneshot <= data_i[2];
        end else if (hit && oneshot) begin
            en      <= 1'b0;
        end
    end

    // Prescale and compare registers, plain software-written storage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc <= '0;
            cmp   <= '0;
        end else begin
            if (wr_presc) presc <= data_i[PSC_W-1:0];
            if (wr_cmp)   cmp   <= data_i;
        end
    end

    // Counter: software write wins over the tick update; wraps modulo 2^DATA_W
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (wr_count) begin
            count <= data_i;
        end else if (hit) begin
            count <= '0;
        end else if (tick) begin
            count <= count + CNT_ONE;
        end
    end

    // Match flag: a new match in the same cycle outranks the write-1-to-clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && data_i[0]) begin
            match <= 1'b0;
        end
    end

    // Interrupt is a pure function of registered state
    assign irq_o = match && ie;

    // Combinational read mux; zero when not reading or for unmapped offsets
    always_comb begin
        data_o = '0;
        if (rd_i) begin
            case (sel)
                OFF_CTRL:   data_o = {{(DATA_W-3){1'b0}}, oneshot, ie, en};
                OFF_PRESC:  data_o = {{(DATA_W-PSC_W){1'b0}}, presc};
                OFF_COUNT:  data_o = count;
                OFF_CMP:    data_o = cmp;
                OFF_STATUS: data_o = {{(DATA_W-1){1'b0}}, match};
                default:    data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pa_soc_timer.sv
// Directed bench for pa_soc_timer: a register-access vector table followed by
// hand-written multi-cycle sequences for counting, matching and collisions.
module tb_pa_soc_timer;

    localparam logic [31:0] A_CTRL   = 32'h0000_0000;
    localparam logic [31:0] A_PRESC  = 32'h0000_0004;
    localparam logic [31:0] A_COUNT  = 32'h0000_0008;
    localparam logic [31:0] A_CMP    = 32'h0000_000C;
    localparam logic [31:0] A_STATUS = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rd;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[19];

    pa_soc_timer #(
        .ADDR_W(32),
        .DATA_W(32),
        .PSC_W (16)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .addr_i (addr),
        .data_i (wdata),
        .we_i   (we),
        .rd_i   (rd),
        .data_o (rdata),
        .irq_o  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        chk(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic idle();
        we = 1'b0;
        rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        rd    = 1'b0;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        we   = 1'b0;
        rd   = 1'b1;
        addr = a;
        #1;
        chk(name, rdata, exp);
        @(posedge clk);
        #1;
        rd   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, A_CTRL,        32'h0,         32'h0};
        vt[1]  = '{1'b1, 1'b0, A_CTRL,        32'hFFFF_FFF6, 32'h0};
        vt[2]  = '{1'b0, 1'b1, A_CTRL,        32'h0,         32'h6};
        vt[3]  = '{1'b1, 1'b0, A_PRESC,       32'h0001_ABCD, 32'h0};
        vt[4]  = '{1'b0, 1'b1, A_PRESC,       32'h0,         32'h0000_ABCD};
        vt[5]  = '{1'b1, 1'b0, A_COUNT,       32'h1234_5678, 32'h0};
        vt[6]  = '{1'b0, 1'b1, 32'h2000_0008, 32'h0,         32'h1234_5678};
        vt[7]  = '{1'b1, 1'b0, A_CMP,         32'hDEAD_BEEF, 32'h0};
        vt[8]  = '{1'b0, 1'b1, A_CMP,         32'h0,         32'hDEAD_BEEF};
        vt[9]  = '{1'b1, 1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 32'h0};
        vt[10] = '{1'b0, 1'b1, 32'h0000_0018, 32'h0,         32'h0};
        vt[11] = '{1'b0, 1'b1, A_COUNT,       32'h0,         32'h1234_5678};
        vt[12] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,         32'h0};
        vt[13] = '{1'b0, 1'b1, 32'h0000_001C, 32'h0,         32'h0};
        vt[14] = '{1'b0, 1'b1, A_STATUS,      32'h0,         32'h0};
        vt[15] = '{1'b1, 1'b0, A_CTRL,        32'h0,         32'h0};
        vt[16] = '{1'b1, 1'b1, A_CTRL,        32'h1,         32'h0};
        vt[17] = '{1'b0, 1'b1, A_CTRL,        32'h0,         32'h1};
        vt[18] = '{1'b1, 1'b0, A_CTRL,        32'h0,         32'h0};

        we    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_irq("reset_irq", 1'b0);
        chk("reset_data_o", rdata, 32'h0);
        rst_n = 1'b1;
        #1;

        // Register access table
        for (int i = 0; i < 19; i++) begin
            we    = vt[i].we;
            rd    = vt[i].rd;
            addr  = vt[i].addr;
            wdata = vt[i].data;
            #1;
            chk($sformatf("vec%0d", i), rdata, vt[i].exp);
            @(posedge clk);
            #1;
        end
        we = 1'b0;
        rd = 1'b0;

        // Periodic mode with match/clear and collisions
        do_reset();
        wr(A_PRESC, 32'h0);
        wr(A_CMP, 32'h3);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            idle();
            chk_irq($sformatf("per_irq_e%0d", k), k == 4);
        end
        wr(A_STATUS, 32'h1);
        chk_irq("per_clear", 1'b0);
        idle();
        idle();
        chk_irq("per_e7", 1'b0);
        idle();
        chk_irq("per_rematch_e8", 1'b1);
        wr(A_STATUS, 32'h1);
        chk_irq("per_clear2", 1'b0);
        idle();
        idle();
        wr(A_STATUS, 32'h1);
        chk_irq("w1c_collision_irq", 1'b1);
        rchk("w1c_collision_status", A_STATUS, 32'h1);
        wr(A_COUNT, 32'h55);
        rchk("count_wr_vs_tick", A_COUNT, 32'h55);
        wr(A_CTRL, 32'h1);
        chk_irq("ie_mask_irq", 1'b0);
        rchk("ie_mask_status_kept", A_STATUS, 32'h1);
        wr(A_CTRL, 32'h0);

        // Prescaler with one-shot
        do_reset();
        wr(A_PRESC, 32'h2);
        wr(A_CMP, 32'h1);
        wr(A_CTRL, 32'h7);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk_irq($sformatf("os_irq_e%0d", k), k == 6);
        end
        rchk("os_en_cleared", A_CTRL, 32'h6);
        rchk("os_count_zero", A_COUNT, 32'h0);
        wr(A_STATUS, 32'h1);
        repeat (10) idle();
        chk_irq("os_no_rematch_irq", 1'b0);
        rchk("os_no_rematch_status", A_STATUS, 32'h0);
        rchk("os_count_held", A_COUNT, 32'h0);

        // Counter wrap without a match
        do_reset();
        wr(A_CMP, 32'h10);
        wr(A_PRESC, 32'h0);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        rchk("wrap_start", A_COUNT, 32'hFFFF_FFFE);
        rchk("wrap_max", A_COUNT, 32'hFFFF_FFFF);
        rchk("wrap_zero", A_COUNT, 32'h0);
        rchk("wrap_no_match", A_STATUS, 32'h0);
        wr(A_CTRL, 32'h0);

        // Asynchronous reset in the middle of counting
        do_reset();
        wr(A_CMP, 32'h5);
        wr(A_CTRL, 32'h3);
        repeat (8) idle();
        chk_irq("pre_reset_irq", 1'b1);
        rst_n = 1'b0;
        #1;
        chk_irq("async_reset_irq", 1'b0);
        for (int a = 0; a < 5; a++) begin
            rd   = 1'b1;
            addr = 32'(a * 4);
            #1;
            chk($sformatf("async_reset_reg%0d", a), rdata, 32'h0);
        end
        rd = 1'b0;
        addr = A_COUNT;
        #1;
        chk("reset_rd_low", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) idle();
        chk_irq("post_reset_irq", 1'b0);
        rchk("post_reset_count", A_COUNT, 32'h0);
        rchk("post_reset_ctrl", A_CTRL, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
